led_status_ctrl: RTL and testbench

LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

---
 rtl/led_status_pkg.sv | 13 +
 rtl/led_pulse_stretch.sv | 26 ++
 rtl/led_status_ctrl.sv | 67 ++++++
 tb/tb_led_status_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_status_pkg.sv
// led_status_pkg: LED mode encodings shared by the LED status controller
package led_status_pkg;

    localparam int ModeWidth = 2;

    typedef enum logic [ModeWidth-1:0] {
        LED_OFF       = 2'd0,
        LED_HEARTBEAT = 2'd1,
        LED_ACTIVITY  = 2'd2,
        LED_DIRECT    = 2'd3
    } led_mode_e;

endpackage

// File: rtl/led_pulse_stretch.sv
// led_pulse_stretch: stretches activity so every trigger is visible for at least StretchCycles cycles
module led_pulse_stretch #(
    parameter int StretchCycles = 1000000
) (
    input  logic clk_sys_i,
    input  logic rst_sys_ni,
    input  logic trig_i,
    output logic active_o
);

    localparam int CntWidth = $clog2(StretchCycles + 1);
    localparam logic [CntWidth-1:0] Reload = CntWidth'(StretchCycles - 1);

    logic [CntWidth-1:0] cnt_q;

    // Reload on every trigger, otherwise count down to zero and hold there
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) cnt_q <= '0;
        else if (trig_i) cnt_q <= Reload;
        else if (cnt_q != '0) cnt_q <= cnt_q - CntWidth'(1);
    end

    // The trigger cycle itself counts, so the indication lasts StretchCycles cycles
    assign active_o = trig_i | (cnt_q != '0);

endmodule

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: per-channel LED driver with off, heartbeat, stretched-activity and direct modes
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int NumLeds       = 3,
    parameter int HbWidth       = 25,
    parameter int StretchCycles = 1000000
) (
    input  logic                              clk_sys_i,
    input  logic                              rst_sys_ni,
    input  logic [NumLeds-1:0][ModeWidth-1:0] mode_i,
    input  logic [NumLeds-1:0]                act_i,
    input  logic [NumLeds-1:0]                direct_i,
    output logic [NumLeds-1:0]                led_o,
    output logic                              heartbeat_o
);

    logic [HbWidth-1:0] hb_cnt_q;
    logic               hb_msb;
    logic [NumLeds-1:0] active;
    logic [NumLeds-1:0] led_d;

    assign hb_msb = hb_cnt_q[HbWidth-1];

    // One free-running counter keeps every heartbeat channel phase-aligned
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) hb_cnt_q <= '0;
        else hb_cnt_q <= hb_cnt_q + HbWidth'(1);
    end

    for (genvar g = 0; g < NumLeds; g++) begin : g_stretch
        led_pulse_stretch #(
            .StretchCycles(StretchCycles)
        ) u_stretch (
            .clk_sys_i (clk_sys_i),
            .rst_sys_ni(rst_sys_ni),
            .trig_i    (act_i[g]),
            .active_o  (active[g])
        );
    end

    // Select each channel's next drive from its mode
    always_comb begin
        led_d = '0;
        for (int n = 0; n < NumLeds; n++) begin
            unique case (led_mode_e'(mode_i[n]))
                LED_OFF:       led_d[n] = 1'b0;
                LED_HEARTBEAT: led_d[n] = hb_msb;
                LED_ACTIVITY:  led_d[n] = active[n];
                LED_DIRECT:    led_d[n] = direct_i[n];
                default:       led_d[n] = 1'b0;
            endcase
        end
    end

    // Register outputs so mode changes land cleanly on the next edge
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            led_o       <= '0;
            heartbeat_o <= 1'b0;
        end else begin
            led_o       <= led_d;
            heartbeat_o <= hb_msb;
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl: randomized and directed checks of led_status_ctrl against a behavioural model
module tb_led_status_ctrl;

    localparam int NL = 3;
    localparam int HB = 4;
    localparam int SC = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NL-1:0][1:0]  mode = '0;
    logic [NL-1:0]       act = '0;
    logic [NL-1:0]       direct = '0;
    logic [NL-1:0]       led_o;
    logic                heartbeat_o;

    int          n_checks = 0;
    int          n_fails = 0;
    int          cur = 0;
    int          last_act [NL];
    logic [NL-1:0] exp_led = '0;
    logic        exp_hb = 1'b0;

    led_status_ctrl #(
        .NumLeds(NL),
        .HbWidth(HB),
        .StretchCycles(SC)
    ) dut (
        .clk_sys_i  (clk),
        .rst_sys_ni (rst_n),
        .mode_i     (mode),
        .act_i      (act),
        .direct_i   (direct),
        .led_o      (led_o),
        .heartbeat_o(heartbeat_o)
    );

    always #5 clk = ~clk;

    // Heartbeat level after the e-th edge since reset: counter value e-1, MSB of HB bits
    function automatic logic hb_level(input int e);
        return ((e - 1) % (1 << HB)) >= (1 << (HB - 1));
    endfunction

    task automatic model_reset();
        cur = 0;
        for (int n = 0; n < NL; n++) last_act[n] = -1000;
    endtask

    // Advance one clock: the model applies the rules to the inputs sampled at this edge
    task automatic step();
        @(posedge clk);
        cur++;
        for (int n = 0; n < NL; n++) begin
            if (act[n]) last_act[n] = cur;
            case (mode[n])
                2'd0: exp_led[n] = 1'b0;
                2'd1: exp_led[n] = hb_level(cur);
                2'd2: exp_led[n] = (cur - last_act[n]) < SC;
                default: exp_led[n] = direct[n];
            endcase
        end
        exp_hb = hb_level(cur);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = {NL{2'd2}};
        act = '1;
        direct = '1;
        @(posedge clk);
        #1;
        n_checks++;
        if (led_o !== '0) begin
            n_fails++;
            $display("FAIL reset_led: got %b want %b", led_o, 3'b000);
        end
        n_checks++;
        if (heartbeat_o !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_hb: got %b want 0", heartbeat_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        act = '0;
        step();
        n_checks++;
        if (led_o !== '0) begin
            n_fails++;
            $display("FAIL reset_act_discard: got %b want %b", led_o, 3'b000);
        end
    endtask

    task automatic test_heartbeat();
        do_reset();
        mode = {NL{2'd1}};
        act = '0;
        for (int i = 0; i < 32; i++) begin
            logic lvl;
            step();
            lvl = ((i / 8) % 2) == 1;
            n_checks++;
            if (led_o !== {NL{lvl}} || led_o !== exp_led) begin
                n_fails++;
                $display("FAIL heartbeat_led step %0d: got %b want %b", i, led_o, {NL{lvl}});
            end
            n_checks++;
            if (heartbeat_o !== lvl) begin
                n_fails++;
                $display("FAIL heartbeat_out step %0d: got %b want %b", i, heartbeat_o, lvl);
            end
        end
    endtask

    task automatic test_stretch();
        int highs;
        int first;
        mode = {2'd0, 2'd0, 2'd2};
        act = '0;
        for (int i = 0; i < SC + 1; i++) step();
        highs = 0;
        first = -1;
        for (int i = 0; i < 10; i++) begin
            act[0] = (i == 0);
            step();
            if (led_o[0]) begin
                highs++;
                if (first < 0) first = i;
            end
            n_checks++;
            if (led_o !== exp_led) begin
                n_fails++;
                $display("FAIL stretch step %0d: got %b want %b", i, led_o, exp_led);
            end
        end
        n_checks++;
        if (highs != SC || first != 0) begin
            n_fails++;
            $display("FAIL stretch_len: got %0d highs from %0d want %0d from 0", highs, first, SC);
        end
    endtask

    task automatic test_retrigger();
        mode = {2'd0, 2'd0, 2'd2};
        act = '0;
        for (int i = 0; i < SC + 1; i++) step();
        for (int c = 0; c <= 10; c++) begin
            act[0] = (c == 0 || c == 3);
            step();
            n_checks++;
            if (led_o[0] !== (c <= 7) || led_o !== exp_led) begin
                n_fails++;
                $display("FAIL retrigger cycle %0d: got %b want %b", c + 1, led_o[0], c <= 7);
            end
        end
        act = '0;
    endtask

    task automatic test_mode_switch();
        mode = '0;
        act = '0;
        direct = '0;
        for (int i = 0; i < SC + 1; i++) step();
        direct[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            mode[1] = (c < 2) ? 2'd3 : 2'd2;
            act[1] = (c == 0);
            step();
            n_checks++;
            if (led_o[1] !== (c <= 4) || led_o !== exp_led) begin
                n_fails++;
                $display("FAIL mode_switch cycle %0d: got %b want %b", c, led_o[1], c <= 4);
            end
        end
        mode[1] = 2'd3;
        step();
        mode[1] = 2'd0;
        step();
        n_checks++;
        if (led_o[1] !== 1'b0) begin
            n_fails++;
            $display("FAIL mode_off: got %b want 0", led_o[1]);
        end
        direct = '0;
    endtask

    task automatic test_reset_mid_stretch();
        mode = {2'd0, 2'd0, 2'd2};
        act = '0;
        act[0] = 1'b1;
        step();
        act[0] = 1'b0;
        step();
        step();
        n_checks++;
        if (led_o[0] !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_stretch_before_reset: got %b want 1", led_o[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (led_o !== '0 || heartbeat_o !== 1'b0) begin
            n_fails++;
            $display("FAIL async_reset: got led %b hb %b want 000 0", led_o, heartbeat_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < SC + 2; i++) begin
            step();
            n_checks++;
            if (led_o[0] !== 1'b0 || led_o !== exp_led) begin
                n_fails++;
                $display("FAIL no_resume step %0d: got %b want 0", i, led_o[0]);
            end
        end
    endtask

    task automatic test_wrap();
        int toggles;
        int last_t;
        logic prev;
        mode = {NL{2'd1}};
        act = '0;
        toggles = 0;
        last_t = -1;
        prev = heartbeat_o;
        for (int i = 0; i < 100; i++) begin
            step();
            n_checks++;
            if (heartbeat_o !== exp_hb || led_o !== exp_led) begin
                n_fails++;
                $display("FAIL wrap_level step %0d: got hb %b led %b want %b %b", i, heartbeat_o, led_o, exp_hb, exp_led);
            end
            if (heartbeat_o !== prev) begin
                if (last_t >= 0) begin
                    n_checks++;
                    if (i - last_t != 8) begin
                        n_fails++;
                        $display("FAIL wrap_interval: got %0d want 8", i - last_t);
                    end
                end
                last_t = i;
                toggles++;
                prev = heartbeat_o;
            end
        end
        n_checks++;
        if (toggles < 12 || toggles > 13) begin
            n_fails++;
            $display("FAIL wrap_toggles: got %0d want 12..13", toggles);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < NL; n++) begin
                if ($urandom_range(7) == 0) mode[n] = 2'($urandom_range(3));
                act[n] = ($urandom_range(5) == 0);
                direct[n] = 1'($urandom_range(1));
            end
            step();
            n_checks++;
            if (led_o !== exp_led || heartbeat_o !== exp_hb) begin
                n_fails++;
                $display("FAIL random step %0d: got led %b hb %b want %b %b", i, led_o, heartbeat_o, exp_led, exp_hb);
            end
        end
        act = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_heartbeat();
        test_stretch();
        test_retrigger();
        test_mode_switch();
        test_reset_mid_stretch();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
